inst_mem_pipe: RTL and testbench

INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_byte_array.sv | 29 ++
 rtl/inst_mem_pipe.sv | 95 +++++++++
 tb/tb_inst_mem_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type and instruction byte-count helper
package imem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  function automatic int inst_bytes(input int inst_w);
    return inst_w / 8;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// imem_byte_array: byte-wide program store with one write port and a B-byte little-endian read
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  localparam int B = inst_bytes(INST_W);

  logic [7:0] mem_q [2**ADDR_W];

  // byte write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  for (genvar i = 0; i < B; i++) begin : g_rd
    assign rdata_o[8*i +: 8] = mem_q[raddr_i + ADDR_W'(i)];
  end

endmodule

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: loadable instruction memory with a latency-1 fetch pipe; IMEM_FAULT_CHECK_EN enables alignment/range faults
module inst_mem_pipe
  import imem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INST_W-1:0] rsp_inst,
  output logic              rsp_fault,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              loading
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [INST_W-1:0] rsp_inst_q, rsp_inst_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              accept, we, start, fault;
  logic [INST_W-1:0] rdata;

  imem_byte_array #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_array (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(ptr_q),
    .wdata_i(ld_byte),
    .raddr_i(req_addr),
    .rdata_o(rdata)
  );

`ifdef IMEM_FAULT_CHECK_EN
  localparam int B  = inst_bytes(INST_W);
  localparam int LB = $clog2(B);
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(B - 1);
  assign fault    = end_addr[ADDR_W] | (req_addr[LB-1:0] != '0);
`else
  assign fault = 1'b0;
`endif

  assign start     = (state_q == RUN) && ld_start;
  assign we        = (state_q == LOAD) && ld_valid;
  assign req_ready = (state_q == RUN) && !ld_start && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  // load FSM: enter LOAD on start, leave after the write tagged last
  always_comb begin
    state_d = start ? LOAD : (we && ld_last) ? RUN : state_q;
    ptr_d   = start ? ld_base : we ? ptr_q + ADDR_W'(1) : ptr_q;
  end

  // response slot: refill on accept, clear on handshake, otherwise hold
  always_comb begin
    rsp_valid_d = accept ? 1'b1 : rsp_ready ? 1'b0 : rsp_valid_q;
    rsp_inst_d  = accept ? (fault ? '0 : rdata) : rsp_inst_q;
    rsp_fault_d = accept ? fault : rsp_fault_q;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;
  assign rsp_fault = rsp_fault_q;
  assign loading   = (state_q == LOAD);

endmodule

// File: tb/tb_inst_mem_pipe.sv
// tb_inst_mem_pipe: randomized and directed checks of inst_mem_pipe against a byte-array reference model
module tb_inst_mem_pipe;

  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int NB    = IW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, rsp_ready = 1'b0;
  logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [AW-1:0] req_addr = '0, ld_base = '0;
  logic [7:0]    ld_byte = '0;
  logic          req_ready, rsp_valid, rsp_fault, loading;
  logic [IW-1:0] rsp_inst;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic          fault;
  } rsp_t;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] pat [$];
  rsp_t       exp_q [$];

  inst_mem_pipe #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_inst (rsp_inst),
    .rsp_fault(rsp_fault),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .loading  (loading)
  );

  always #5 clk = ~clk;

  function automatic rsp_t expect_rsp(input int addr);
    rsp_t r;
    r.fault = FAULT_EN && (((addr % NB) != 0) || (addr + NB > DEPTH));
    r.inst  = '0;
    if (!r.fault)
      for (int k = 0; k < NB; k++) r.inst[8*k +: 8] = ref_mem[(addr + k) % DEPTH];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_body(input int base);
    for (int k = 0; k < pat.size(); k++) begin
      ld_valid = 1'b1;
      ld_byte  = pat[k];
      ld_last  = (k == pat.size() - 1);
      ref_mem[(base + k) % DEPTH] = pat[k];
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (loading !== 1'b0) begin
      failures++;
      $display("FAIL load_end: loading=%b expected 0", loading);
    end
  endtask

  task automatic start_load(input int base);
    ld_start = 1'b1;
    ld_base  = AW'(base);
    tick();
    ld_start = 1'b0;
    checks++;
    if (loading !== 1'b1) begin
      failures++;
      $display("FAIL load_start: loading=%b expected 1", loading);
    end
  endtask

  task automatic load(input int base);
    start_load(base);
    load_body(base);
  endtask

  task automatic fetch_check(input int addr, input string name, input logic [IW-1:0] e_inst, input logic e_fault);
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: req_ready=%b expected 1", name, req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== e_inst || rsp_fault !== e_fault) begin
      failures++;
      $display("FAIL %s: valid=%b inst=%h fault=%b expected valid=1 inst=%h fault=%b",
               name, rsp_valid, rsp_inst, rsp_fault, e_inst, e_fault);
    end
    tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    reset     = 1'b0;
    req_valid = 1'b1;
    req_addr  = '0;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pending: rsp_valid=%b expected 1", rsp_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_inst !== '0 || rsp_fault !== 1'b0 || loading !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b inst=%h fault=%b loading=%b expected all 0",
               rsp_valid, rsp_inst, rsp_fault, loading);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_fill;
    rsp_t r;
    int   a;
    pat.delete();
    for (int k = 0; k < DEPTH; k++) pat.push_back(8'($urandom));
    load(0);
    for (int n = 0; n < 4; n++) begin
      a = $urandom_range(0, DEPTH - 1) & ~(NB - 1);
      r = expect_rsp(a);
      fetch_check(a, "fill_fetch", r.inst, r.fault);
    end
  endtask

  task automatic test_back_to_back;
    pat = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
    load(0);
    req_valid = 1'b1;
    req_addr  = 12'h000;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h00000003) begin
      failures++;
      $display("FAIL b2b_first: valid=%b inst=%h expected 1 00000003", rsp_valid, rsp_inst);
    end
    req_addr = 12'h004;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: req_ready=%b expected 1", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h00000006) begin
      failures++;
      $display("FAIL b2b_second: valid=%b inst=%h expected 1 00000006", rsp_valid, rsp_inst);
    end
    rsp_ready = 1'b0;
    req_addr  = 12'h000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready: cycle %0d req_ready=%b expected 0", c, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_inst !== 32'h00000006) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d valid=%b inst=%h expected 1 00000006", c, rsp_valid, rsp_inst);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: rsp_valid=%b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_duplicate: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_wrap;
    pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(12'hFFE);
    fetch_check(12'hFFE, "wrap", FAULT_EN ? 32'h0 : 32'hDDCCBBAA, FAULT_EN);
  endtask

  task automatic test_misaligned;
    fetch_check(12'h002, "misaligned", FAULT_EN ? 32'h0 : 32'h00060000, FAULT_EN);
  endtask

  task automatic test_ld_start_drain;
    rsp_t r;
    req_valid = 1'b1;
    req_addr  = 12'h004;
    rsp_ready = 1'b0;
    tick();
    rsp_ready = 1'b1;
    ld_start  = 1'b1;
    ld_base   = 12'h100;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ldstart_ready: req_ready=%b expected 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h00000006) begin
      failures++;
      $display("FAIL ldstart_rsp: valid=%b inst=%h expected 1 00000006", rsp_valid, rsp_inst);
    end
    tick();
    ld_start  = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (loading !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ldstart_next: loading=%b valid=%b expected 1 0", loading, rsp_valid);
    end
    pat.delete();
    for (int k = 0; k < 3; k++) pat.push_back(8'($urandom));
    load_body(12'h100);
    r = expect_rsp(12'h100);
    fetch_check(12'h100, "after_load", r.inst, r.fault);
  endtask

  task automatic test_reset_mid_load;
    rsp_t r;
    start_load(12'h200);
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      ld_last  = 1'b0;
      ref_mem[12'h200 + k] = ld_byte;
      tick();
    end
    ld_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (loading !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: loading=%b valid=%b expected 0 0", loading, rsp_valid);
    end
    ld_valid = 1'b1;
    ld_byte  = ~ref_mem[12'h202];
    tick();
    ld_valid = 1'b0;
    r = expect_rsp(12'h200);
    fetch_check(12'h200, "midload_bytes", r.inst, r.fault);
  endtask

  task automatic test_random;
    rsp_t e;
    logic held;
    logic [IW-1:0] prev_inst;
    logic prev_fault;
    int base;
    for (int rep = 0; rep < 5; rep++) begin
      base = $urandom_range(0, DEPTH - 1);
      pat.delete();
      for (int k = 0; k < $urandom_range(1, 12); k++) pat.push_back(8'($urandom));
      load(base);
      held = 1'b0;
      for (int c = 0; c < 40; c++) begin
        req_valid = 1'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        req_addr  = AW'($urandom);
        if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~AW'(NB - 1);
        #1;
        checks++;
        if (rsp_valid !== (exp_q.size() != 0) || req_ready !== (exp_q.size() == 0 || rsp_ready)) begin
          failures++;
          $display("FAIL rand_handshake: valid=%b ready=%b expected valid=%b ready=%b",
                   rsp_valid, req_ready, exp_q.size() != 0, exp_q.size() == 0 || rsp_ready);
        end
        if (held) begin
          checks++;
          if (rsp_inst !== prev_inst || rsp_fault !== prev_fault) begin
            failures++;
            $display("FAIL rand_hold: inst=%h fault=%b expected %h %b", rsp_inst, rsp_fault, prev_inst, prev_fault);
          end
        end
        if (exp_q.size() != 0 && rsp_ready) begin
          e = exp_q.pop_front();
          checks++;
          if (rsp_inst !== e.inst || rsp_fault !== e.fault) begin
            failures++;
            $display("FAIL rand_rsp: inst=%h fault=%b expected %h %b", rsp_inst, rsp_fault, e.inst, e.fault);
          end
        end
        if (req_valid && (exp_q.size() == 0)) exp_q.push_back(expect_rsp(int'(req_addr)));
        held       = (exp_q.size() != 0) && !rsp_ready && rsp_valid;
        prev_inst  = rsp_inst;
        prev_fault = rsp_fault;
        tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== e.inst || rsp_fault !== e.fault) begin
          failures++;
          $display("FAIL rand_drain: valid=%b inst=%h fault=%b expected 1 %h %b",
                   rsp_valid, rsp_inst, rsp_fault, e.inst, e.fault);
        end
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_empty: rsp_valid=%b expected 0", rsp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    test_ld_start_drain();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
